// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        FILL,
        DONE,
        ERROR
    } state_e;

    localparam int         INSTR_WIDTH       = 32;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four little-endian bytes into one instruction word.
// The word and its valid pulse are presented combinationally alongside the
// fourth byte, so the caller can register the imem write one cycle later.
module imem_word_packer
    import loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             byte_in,
    input  logic                   byte_en,
    output logic [INSTR_WIDTH-1:0] word_out,
    output logic                   word_vld
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] acc_q, acc_d;

    // Shift bytes in from the top so the first byte ends up in bits [7:0]
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (byte_en) begin
            cnt_d = cnt_q + 2'd1;
            acc_d = {byte_in, acc_q[23:8]};
        end
    end

    // Byte counter and partial-word register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
            acc_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign word_out = {byte_in, acc_q};
    assign word_vld = byte_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a framed program, writes it to imem,
// zero-fills the unused words and releases the pipeline reset once the
// checksum has been verified.
module imem_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 5,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_waddr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_rst,
    output logic                   load_done,
    output logic                   load_err
);

    localparam int            DEPTH   = 2 ** ADDR_WIDTH;
    // One extra bit so an index equal to DEPTH is representable
    localparam int            IW      = ADDR_WIDTH + 1;
    localparam logic [IW-1:0] DEPTH_W = IW'(DEPTH);

    state_e                   state_q, state_d;
    logic [IW-1:0]            n_q, n_d;
    // Word index during DATA, then reused as the fill address during FILL
    logic [IW-1:0]            idx_q, idx_d;
    logic [7:0]               chk_q, chk_d;
    logic                     ready_q, ready_d;
    logic                     we_q, we_d;
    logic [ADDR_WIDTH-1:0]    waddr_q, waddr_d;
    logic [INSTR_WIDTH-1:0]   wdata_q, wdata_d;
    logic                     cpu_rst_q, cpu_rst_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic                     accept;
    logic                     pk_en;
    logic [INSTR_WIDTH-1:0]   pk_word;
    logic                     pk_vld;

    assign accept = byte_valid && ready_q;
    assign pk_en  = accept && (state_q == DATA);

    imem_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .byte_in  (byte_in),
        .byte_en  (pk_en),
        .word_out (pk_word),
        .word_vld (pk_vld)
    );

    // Next-state logic; every output is derived here and registered below
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (accept && byte_in == SYNC_BYTE) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (accept) begin
                    chk_d = byte_in;
                    if ({1'b0, byte_in} > 9'(DEPTH)) begin
                        state_d = ERROR;
                    end else begin
                        n_d   = byte_in[IW-1:0];
                        idx_d = '0;
                        state_d = (byte_in == 8'd0) ? CHECK : DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    chk_d = chk_q ^ byte_in;
                    if (pk_vld) begin
                        we_d    = 1'b1;
                        waddr_d = idx_q[ADDR_WIDTH-1:0];
                        wdata_d = pk_word;
                        idx_d   = idx_q + IW'(1);
                        if (idx_q + IW'(1) == n_q) begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (byte_in != chk_q) begin
                        state_d = ERROR;
                    end else if (n_q == DEPTH_W) begin
                        state_d = DONE;
                    end else begin
                        // First fill write goes out the cycle after CHK
                        we_d    = 1'b1;
                        waddr_d = n_q[ADDR_WIDTH-1:0];
                        wdata_d = '0;
                        idx_d   = n_q + IW'(1);
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (idx_q == DEPTH_W) begin
                    state_d = DONE;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = idx_q[ADDR_WIDTH-1:0];
                    wdata_d = '0;
                    idx_d   = idx_q + IW'(1);
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase

        ready_d   = (state_d == IDLE) || (state_d == COUNT) ||
                    (state_d == DATA) || (state_d == CHECK);
        cpu_rst_d = (state_d != DONE);
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERROR);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            idx_q     <= '0;
            chk_q     <= 8'd0;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign byte_ready = ready_q;
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of whole frames plus hand-written
// sequences for full-depth load, gapped stream timing and mid-frame reset.
module tb_imem_loader;

    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    byte_in = 8'd0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          load_done;
    logic          load_err;

    imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    // Write monitor: every imem write, in order
    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];
    always @(negedge clk) begin
        if (rst && imem_we) begin
            log_addr.push_back(imem_waddr);
            log_data.push_back(imem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time bound, got no finish, required finish");
        $fatal(1, "timeout");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   32'(byte_ready), 32'd1);
        check({tag, "_we"},      32'(imem_we),    32'd0);
        check({tag, "_waddr"},   32'(imem_waddr), 32'd0);
        check({tag, "_wdata"},   imem_wdata,      32'd0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst),    32'd1);
        check({tag, "_done"},    32'(load_done),  32'd0);
        check({tag, "_err"},     32'(load_err),   32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        byte_valid = 1'b0;
        rst = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Offer one byte after 'gap' idle cycles; returns one cycle after acceptance
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_in = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!byte_ready) begin
            errors++;
            $display("FAIL send_timeout: byte %h got byte_ready=0 required 1", b);
        end else begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
    endtask

    // Cycles from the acceptance edge of the last byte until cpu_rst is low
    task automatic wait_release(output int lat);
        lat = 1;
        while (cpu_rst && lat < 80) begin @(posedge clk); #1; lat++; end
    endtask

    logic [31:0] mem [DEPTH];
    int          order_bad;

    task automatic build_mem(input int base);
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hBAD0_BAD0;
        order_bad = 0;
        for (int k = base; k < log_addr.size(); k++) begin
            mem[log_addr[k]] = log_data[k];
            if (int'(log_addr[k]) != k - base) order_bad++;
        end
    endtask

    typedef struct {
        int          start;
        int          len;
        bit          exp_done;
        bit          exp_err;
        int          exp_wr;
        logic [31:0] exp_w0;
        logic [31:0] exp_w3;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [6];
    logic [7:0]  pool [49];
    logic [AW-1:0] ref_addr[$];
    logic [31:0]   ref_data[$];

    initial begin
        int lat;
        int base;
        int bad;
        logic [7:0] b;

        pool = '{
            // v0: four-word program (19 bytes)
            8'hA5, 8'h04,
            8'h00, 8'h00, 8'h40, 8'h40,
            8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h8A,
            8'h8E,
            // v1: garbage then one word, good checksum (9)
            8'h11, 8'h22, 8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23,
            // v2: same frame, bad checksum (9)
            8'h11, 8'h22, 8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h34,
            // v3: N=0 (3)
            8'hA5, 8'h00, 8'h00,
            // v4: N=33 (2)
            8'hA5, 8'h21,
            // v5: sync value inside data is plain data (7)
            8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01
        };
        //          start len done err wr  w0             w3             lat
        vecs[0] = '{0,   19, 1'b1, 1'b0, 32, 32'h4040_0000, 32'h8A00_0000, 29};
        vecs[1] = '{19,  9,  1'b1, 1'b0, 32, 32'hDEAD_BEEF, 32'h0000_0000, 32};
        vecs[2] = '{28,  9,  1'b0, 1'b1, 1,  32'hDEAD_BEEF, 32'hBAD0_BAD0, 0};
        vecs[3] = '{37,  3,  1'b1, 1'b0, 32, 32'h0000_0000, 32'h0000_0000, 33};
        vecs[4] = '{40,  2,  1'b0, 1'b1, 0,  32'hBAD0_BAD0, 32'hBAD0_BAD0, 0};
        vecs[5] = '{42,  7,  1'b1, 1'b0, 32, 32'hA5A5_A5A5, 32'h0000_0000, 32};

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < 6; v++) begin
            do_reset();
            base = log_addr.size();
            for (int j = 0; j < vecs[v].len; j++) send(pool[vecs[v].start + j], 0);
            if (vecs[v].exp_err) check($sformatf("v%0d_err_immediate", v), 32'(load_err), 32'd1);
            wait_release(lat);
            if (vecs[v].exp_lat != 0) check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            repeat (4) @(posedge clk);
            #1;
            build_mem(base);
            check($sformatf("v%0d_writes", v), 32'(log_addr.size() - base), 32'(vecs[v].exp_wr));
            check($sformatf("v%0d_done", v),   32'(load_done), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_err", v),    32'(load_err),  32'(vecs[v].exp_err));
            check($sformatf("v%0d_cpu_rst", v), 32'(cpu_rst),  32'(!vecs[v].exp_done));
            check($sformatf("v%0d_ready", v),  32'(byte_ready), 32'd0);
            check($sformatf("v%0d_w0", v),     mem[0], vecs[v].exp_w0);
            check($sformatf("v%0d_w3", v),     mem[3], vecs[v].exp_w3);
            check($sformatf("v%0d_order", v),  32'(order_bad), 32'd0);
            if (v == 0) begin
                for (int k = base; k < log_addr.size(); k++) begin
                    ref_addr.push_back(log_addr[k]);
                    ref_data.push_back(log_data[k]);
                end
            end
            $display("vector %0d: writes=%0d lat=%0d done=%0d err=%0d imem[0]=%h",
                     v, log_addr.size() - base, lat, load_done, load_err, mem[0]);
        end

        // ---------------- N = DEPTH: no fill ----------------
        do_reset();
        base = log_addr.size();
        send(8'hA5, 0);
        send(8'h20, 0);
        for (int j = 0; j < 4 * DEPTH; j++) begin
            b = j[7:0];
            send(b, 0);
        end
        send(8'h20, 0);
        wait_release(lat);
        check("full_latency", 32'(lat), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        build_mem(base);
        bad = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (mem[k] !== {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}) bad++;
        end
        check("full_image", 32'(bad), 32'd0);
        check("full_writes", 32'(log_addr.size() - base), 32'(DEPTH));
        check("full_done", 32'(load_done), 32'd1);
        $display("full-depth frame: writes=%0d lat=%0d done=%0d", log_addr.size() - base, lat, load_done);

        // ---------------- gapped stream vs constant valid ----------------
        do_reset();
        base = log_addr.size();
        for (int j = 0; j < vecs[0].len; j++) send(pool[j], int'($urandom_range(0, 3)));
        wait_release(lat);
        check("gap_latency", 32'(lat), 32'd29);
        repeat (3) @(posedge clk);
        #1;
        check("gap_writes", 32'(log_addr.size() - base), 32'(ref_addr.size()));
        bad = 0;
        for (int k = 0; k < ref_addr.size() && base + k < log_addr.size(); k++) begin
            if (log_addr[base + k] !== ref_addr[k] || log_data[base + k] !== ref_data[k]) bad++;
        end
        check("gap_sequence", 32'(bad), 32'd0);
        $display("gapped frame: writes=%0d lat=%0d done=%0d", log_addr.size() - base, lat, load_done);

        // ---------------- reset in the middle of DATA ----------------
        do_reset();
        send(8'hA5, 0);
        send(8'h03, 0);
        for (int j = 0; j < 9; j++) begin
            b = 8'h11 + j[7:0];
            send(b, 0);
        end
        check("mid_waddr_before", 32'(imem_waddr), 32'd1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(posedge clk); #1 rst = 1'b1;
        base = log_addr.size();
        for (int j = 0; j < vecs[0].len; j++) send(pool[j], 0);
        wait_release(lat);
        check("reload_latency", 32'(lat), 32'd29);
        repeat (3) @(posedge clk);
        #1;
        build_mem(base);
        check("reload_done", 32'(load_done), 32'd1);
        check("reload_w0", mem[0], 32'h4040_0000);
        check("reload_w3", mem[3], 32'h8A00_0000);
        check("reload_writes", 32'(log_addr.size() - base), 32'd32);
        $display("reload after mid-frame reset: writes=%0d lat=%0d done=%0d", log_addr.size() - base, lat, load_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
